// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath/memory.
// Latency: none, wires only.
// Backpressure: none; the controller advances one state per clock.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       fault;
  logic [3:0] state;

  // controller side
  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, fault, state
  );

  // datapath side
  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (lw/sw/R/I/beq/jal) with sticky FAULT on bad encodings; BNE_EN adds bne.
// Latency: Moore outputs per state, BRANCH PCWrite is Mealy on Zero; 3-5 cycles per instruction.
// Backpressure: none; one state transition every clock, FAULT holds until rst_n.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    FAULT    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q, state_d;
  logic       pc_write, ir_write, mem_write, reg_write;
  logic       adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctl, alu_dec;
  logic       alu_f3_ok, branch_ok, branch_take;

  // ALU operation for R/I execute states and whether funct3 is a supported ALU op
  always_comb begin
    alu_dec   = 3'b000;
    alu_f3_ok = 1'b0;
    case (ctl.funct3)
      3'b000: begin alu_dec = (ctl.op[5] & ctl.funct7b5) ? 3'b001 : 3'b000; alu_f3_ok = 1'b1; end
      3'b010: begin alu_dec = 3'b101; alu_f3_ok = 1'b1; end
      3'b110: begin alu_dec = 3'b011; alu_f3_ok = 1'b1; end
      3'b111: begin alu_dec = 3'b010; alu_f3_ok = 1'b1; end
      default: ;
    endcase
  end

`ifdef BNE_EN
  // beq and bne both legal; funct3[0] inverts the taken sense
  assign branch_ok   = (ctl.funct3 == 3'b000) || (ctl.funct3 == 3'b001);
  assign branch_take = ctl.Zero ^ ctl.funct3[0];
`else
  // beq only
  assign branch_ok   = (ctl.funct3 == 3'b000);
  assign branch_take = ctl.Zero;
`endif

  // state register; reset lands in FETCH so the first edge after release fetches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // next state and per-state control outputs
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctl    = 3'b000;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (ctl.op)
          OP_LW, OP_SW: state_d = (ctl.funct3 == 3'b010) ? MEMADR : FAULT;
          OP_R:         state_d = alu_f3_ok ? EXECUTER : FAULT;
          OP_I:         state_d = alu_f3_ok ? EXECUTEI : FAULT;
          OP_B:         state_d = branch_ok ? BRANCH : FAULT;
          OP_JAL:       state_d = JAL;
          default:      state_d = FAULT;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (ctl.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = FETCH;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_ctl   = alu_dec;
        state_d   = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctl   = alu_dec;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctl   = 3'b001;
        pc_write  = branch_take;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // immediate format follows op directly, independent of state
  always_comb begin
    imm_src = 2'b00;
    case (ctl.op)
      OP_SW:   imm_src = 2'b01;
      OP_B:    imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // write enables are gated by rst_n so nothing commits while reset is held
  assign ctl.PCWrite    = pc_write  & rst_n;
  assign ctl.IRWrite    = ir_write  & rst_n;
  assign ctl.MemWrite   = mem_write & rst_n;
  assign ctl.RegWrite   = reg_write & rst_n;
  assign ctl.AdrSrc     = adr_src;
  assign ctl.ResultSrc  = result_src;
  assign ctl.ALUSrcA    = alu_src_a;
  assign ctl.ALUSrcB    = alu_src_b;
  assign ctl.ALUControl = alu_ctl;
  assign ctl.ImmSrc     = imm_src;
  assign ctl.fault      = (state_q == FAULT);
  assign ctl.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes hand-computed output vectors per cycle,
// a monitor pops and compares them against the DUT outputs mid-cycle.
// Vector layout: state[20:17] fault[16] PCWrite AdrSrc MemWrite IRWrite RegWrite[15:11] ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc.
module tb_multicycle_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [20:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b0000000;

  localparam logic [20:0] PCW = 21'h008000;

  //                               state  flt   P A M I R   RS     SA     SB     ALU     IMM
  localparam logic [20:0] S_RST  = {4'd0, 1'b0, 5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
  localparam logic [20:0] S_FET  = {4'd0, 1'b0, 5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
  localparam logic [20:0] S_DEC  = {4'd1, 1'b0, 5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00};
  localparam logic [20:0] S_MADR = {4'd2, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00};
  localparam logic [20:0] S_MRD  = {4'd3, 1'b0, 5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [20:0] S_MWB  = {4'd4, 1'b0, 5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [20:0] S_MWR  = {4'd5, 1'b0, 5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [20:0] S_EXR  = {4'd6, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [20:0] S_EXI  = {4'd7, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00};
  localparam logic [20:0] S_AWB  = {4'd8, 1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [20:0] S_BR   = {4'd9, 1'b0, 5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00};
  localparam logic [20:0] S_JAL  = {4'd10,1'b0, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00};
  localparam logic [20:0] S_FLT  = {4'd11,1'b1, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};

  wire [20:0] obs = {bus.state, bus.fault, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                     bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc};

  // merge ALU op and immediate format into a state vector
  function automatic logic [20:0] w(input logic [20:0] base, input logic [2:0] alu, input logic [1:0] imm);
    return base | {16'b0, alu, imm};
  endfunction

  // drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input string nm, input logic r, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z, input logic [20:0] e);
    exp_t x;
    @(negedge clk);
    #1;
    rst_n        = r;
    bus.op       = o;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.Zero     = z;
    x.nm = nm;
    x.v  = e;
    sb_q.push_back(x);
  endtask

  // monitor: compare the DUT outputs with the queued expectation each cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        if (obs !== x.v) begin
          errors++;
          $display("FAIL %s got %h expected %h", x.nm, obs, x.v);
        end
      end
    end
  end

  initial begin
    bus.op       = ILL;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    #1 rst_n = 1'b0;

    // reset held three cycles
    repeat (3) step("reset", 1'b0, ILL, 3'b000, 1'b0, 1'b0, S_RST);

    // lw: 0,1,2,3,4
    step("lw_fetch",   1'b1, LW, 3'b010, 1'b0, 1'b0, S_FET);
    step("lw_decode",  1'b1, LW, 3'b010, 1'b0, 1'b0, S_DEC);
    step("lw_memadr",  1'b1, LW, 3'b010, 1'b0, 1'b0, S_MADR);
    step("lw_memread", 1'b1, LW, 3'b010, 1'b0, 1'b0, S_MRD);
    step("lw_memwb",   1'b1, LW, 3'b010, 1'b0, 1'b0, S_MWB);

    // sw: 0,1,2,5 with S immediate
    step("sw_fetch",    1'b1, SW, 3'b010, 1'b0, 1'b0, w(S_FET,  3'b000, 2'b01));
    step("sw_decode",   1'b1, SW, 3'b010, 1'b0, 1'b0, w(S_DEC,  3'b000, 2'b01));
    step("sw_memadr",   1'b1, SW, 3'b010, 1'b0, 1'b0, w(S_MADR, 3'b000, 2'b01));
    step("sw_memwrite", 1'b1, SW, 3'b010, 1'b0, 1'b0, w(S_MWR,  3'b000, 2'b01));

    // beq taken
    step("beq1_fetch",  1'b1, BR, 3'b000, 1'b0, 1'b1, w(S_FET, 3'b000, 2'b10));
    step("beq1_decode", 1'b1, BR, 3'b000, 1'b0, 1'b1, w(S_DEC, 3'b000, 2'b10));
    step("beq1_branch", 1'b1, BR, 3'b000, 1'b0, 1'b1, w(S_BR | PCW, 3'b000, 2'b10));
    // beq not taken
    step("beq0_fetch",  1'b1, BR, 3'b000, 1'b0, 1'b0, w(S_FET, 3'b000, 2'b10));
    step("beq0_decode", 1'b1, BR, 3'b000, 1'b0, 1'b0, w(S_DEC, 3'b000, 2'b10));
    step("beq0_branch", 1'b1, BR, 3'b000, 1'b0, 1'b0, w(S_BR, 3'b000, 2'b10));

    // R-type sub
    step("sub_fetch",  1'b1, RT, 3'b000, 1'b1, 1'b0, S_FET);
    step("sub_decode", 1'b1, RT, 3'b000, 1'b1, 1'b0, S_DEC);
    step("sub_exec",   1'b1, RT, 3'b000, 1'b1, 1'b0, w(S_EXR, 3'b001, 2'b00));
    step("sub_aluwb",  1'b1, RT, 3'b000, 1'b1, 1'b0, S_AWB);
    // R-type slt and and
    step("slt_fetch",  1'b1, RT, 3'b010, 1'b0, 1'b0, S_FET);
    step("slt_decode", 1'b1, RT, 3'b010, 1'b0, 1'b0, S_DEC);
    step("slt_exec",   1'b1, RT, 3'b010, 1'b0, 1'b0, w(S_EXR, 3'b101, 2'b00));
    step("slt_aluwb",  1'b1, RT, 3'b010, 1'b0, 1'b0, S_AWB);
    step("and_fetch",  1'b1, RT, 3'b111, 1'b0, 1'b0, S_FET);
    step("and_decode", 1'b1, RT, 3'b111, 1'b0, 1'b0, S_DEC);
    step("and_exec",   1'b1, RT, 3'b111, 1'b0, 1'b0, w(S_EXR, 3'b010, 2'b00));
    step("and_aluwb",  1'b1, RT, 3'b111, 1'b0, 1'b0, S_AWB);

    // I-type addi with funct7b5=1 stays add; ori
    step("addi_fetch",  1'b1, IT, 3'b000, 1'b1, 1'b0, S_FET);
    step("addi_decode", 1'b1, IT, 3'b000, 1'b1, 1'b0, S_DEC);
    step("addi_exec",   1'b1, IT, 3'b000, 1'b1, 1'b0, w(S_EXI, 3'b000, 2'b00));
    step("addi_aluwb",  1'b1, IT, 3'b000, 1'b1, 1'b0, S_AWB);
    step("ori_fetch",   1'b1, IT, 3'b110, 1'b0, 1'b0, S_FET);
    step("ori_decode",  1'b1, IT, 3'b110, 1'b0, 1'b0, S_DEC);
    step("ori_exec",    1'b1, IT, 3'b110, 1'b0, 1'b0, w(S_EXI, 3'b011, 2'b00));
    step("ori_aluwb",   1'b1, IT, 3'b110, 1'b0, 1'b0, S_AWB);

    // jal with J immediate
    step("jal_fetch",  1'b1, JL, 3'b000, 1'b0, 1'b0, w(S_FET, 3'b000, 2'b11));
    step("jal_decode", 1'b1, JL, 3'b000, 1'b0, 1'b0, w(S_DEC, 3'b000, 2'b11));
    step("jal_jal",    1'b1, JL, 3'b000, 1'b0, 1'b0, w(S_JAL, 3'b000, 2'b11));
    step("jal_aluwb",  1'b1, JL, 3'b000, 1'b0, 1'b0, w(S_AWB, 3'b000, 2'b11));

    // bne: legal only with BNE_EN, where Zero=0 means taken
    step("bne_fetch",  1'b1, BR, 3'b001, 1'b0, 1'b0, w(S_FET, 3'b000, 2'b10));
    step("bne_decode", 1'b1, BR, 3'b001, 1'b0, 1'b0, w(S_DEC, 3'b000, 2'b10));
`ifdef BNE_EN
    step("bne_branch", 1'b1, BR, 3'b001, 1'b0, 1'b0, w(S_BR | PCW, 3'b000, 2'b10));
`else
    step("bne_fault",  1'b1, BR, 3'b001, 1'b0, 1'b0, w(S_FLT, 3'b000, 2'b10));
    step("bne_rst",    1'b0, BR, 3'b001, 1'b0, 1'b0, w(S_RST, 3'b000, 2'b10));
`endif

    // lw with illegal funct3 faults after DECODE
    step("lwbad_fetch",  1'b1, LW, 3'b000, 1'b0, 1'b0, S_FET);
    step("lwbad_decode", 1'b1, LW, 3'b000, 1'b0, 1'b0, S_DEC);
    step("lwbad_fault",  1'b1, LW, 3'b000, 1'b0, 1'b0, S_FLT);
    step("lwbad_rst",    1'b0, LW, 3'b000, 1'b0, 1'b0, S_RST);

    // reset mid-instruction (in MEMREAD) aborts the lw
    step("abort_fetch",  1'b1, LW, 3'b010, 1'b0, 1'b0, S_FET);
    step("abort_decode", 1'b1, LW, 3'b010, 1'b0, 1'b0, S_DEC);
    step("abort_memadr", 1'b1, LW, 3'b010, 1'b0, 1'b0, S_MADR);
    step("abort_rst",    1'b0, LW, 3'b010, 1'b0, 1'b0, S_RST);

    // illegal op: sticky FAULT for 10 cycles, then reset pulse returns to FETCH
    step("ill_fetch",  1'b1, ILL, 3'b000, 1'b0, 1'b0, S_FET);
    step("ill_decode", 1'b1, ILL, 3'b000, 1'b0, 1'b0, S_DEC);
    repeat (10) step("ill_fault", 1'b1, ILL, 3'b000, 1'b0, 1'b1, S_FLT);
    step("ill_rst",    1'b0, ILL, 3'b000, 1'b0, 1'b0, S_RST);
    step("ill_refetch", 1'b1, ILL, 3'b000, 1'b0, 1'b0, S_FET);

    // let the monitor drain the last entry, then confirm nothing was left unchecked
    @(negedge clk);
    #5;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
